uart_serial_device: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_serial_device_if.sv | 26 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_serial_device.sv | 179 +++++++++++++++++
 tb/tb_uart_serial_device.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, default sizing and the parity helper used by TX and RX.
package uart_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BAUD_DIV   = 16;
  localparam int MAX_DATA_WIDTH     = 9;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/uart_serial_device_if.sv
// Parallel handshake and serial line signals of one UART endpoint.
interface uart_serial_device_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx;
  logic                  rx;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_parity_err;
  logic                  rx_framing_err;

  modport slave (
    input  tx_data, tx_valid, rx,
    output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_framing_err
  );

  modport master (
    output tx_data, tx_valid, rx,
    input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_framing_err
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads a start value and flags terminal count, parking at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter  int BAUD_DIV = DEFAULT_BAUD_DIV,
  localparam int TW       = $clog2(BAUD_DIV)
) (
  input  logic          pclk,
  input  logic          areset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          tc_o
);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/uart_serial_device.sv
// Full-duplex UART endpoint: TX serializer, RX deserializer and rx synchronizer.
//   state     | meaning
//   IDLE      | TX: waiting for tx_valid          RX: waiting for a low on the line
//   START     | TX: driving start bit             RX: half-bit wait, reject glitches
//   DATA      | TX/RX: shifting data, LSB first
//   PARITY    | TX/RX: parity bit (only when enabled)
//   STOP      | TX: stop bit(s)                   RX: waiting for the stop-bit centre
//   BREAK     | RX only: stop bit was low, wait for the line to return high
module uart_serial_device
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic                 pclk,
  input logic                 areset,
  uart_serial_device_if.slave bus
);
  localparam int TW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic ODD_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  tx_state_e             tx_state_q, tx_state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [CW-1:0]         tx_cnt_q;
  logic                  tx_par_q, tx_rdy_q;
  logic                  tx_tc, tx_load, tx_accept, tx_bit;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
    .pclk(pclk), .areset(areset), .load_i(tx_load), .load_val_i(BIT_LOAD), .tc_o(tx_tc)
  );

  assign tx_accept    = bus.tx_valid && bus.tx_ready;
  assign bus.tx_ready = tx_rdy_q && (tx_state_q == TX_IDLE);
  assign bus.tx       = tx_bit;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) tx_state_q <= TX_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:   if (tx_accept) tx_state_d = TX_START;
      TX_START:  if (tx_tc) tx_state_d = TX_DATA;
      TX_DATA:   if (tx_tc && tx_cnt_q == LAST_DATA)
                   tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tc) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_tc && tx_cnt_q == LAST_STOP) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // Line level comes straight from the state register so reset forces it high at once.
  always_comb begin
    tx_bit  = 1'b1;
    tx_load = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:   tx_load = tx_accept;
      TX_START:  begin tx_bit = 1'b0;          tx_load = tx_tc; end
      TX_DATA:   begin tx_bit = tx_shift_q[0]; tx_load = tx_tc; end
      TX_PARITY: begin tx_bit = tx_par_q;      tx_load = tx_tc; end
      TX_STOP:   tx_load = tx_tc && (tx_state_d != TX_IDLE);
      default:   ;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_rdy_q   <= 1'b0;
    end else begin
      tx_rdy_q <= 1'b1;
      if (tx_accept) begin
        tx_shift_q <= bus.tx_data;
        tx_par_q   <= parity_calc(MAX_DATA_WIDTH'(bus.tx_data), ODD_MODE);
        tx_cnt_q   <= '0;
      end else if (tx_tc && tx_state_q == TX_DATA) begin
        tx_shift_q <= tx_shift_q >> 1;
        tx_cnt_q   <= (tx_cnt_q == LAST_DATA) ? '0 : tx_cnt_q + 1'b1;
      end else if (tx_tc && tx_state_q == TX_STOP && tx_cnt_q != LAST_STOP) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  rx_state_e             rx_state_q, rx_state_d;
  logic                  rx_meta_q, rx_sync_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_data_q;
  logic [CW-1:0]         rx_cnt_q;
  logic                  rx_par_q, rx_valid_q, rx_perr_q, rx_ferr_q;
  logic                  rx_tc, rx_load;
  logic [TW-1:0]         rx_load_val;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
    .pclk(pclk), .areset(areset), .load_i(rx_load), .load_val_i(rx_load_val), .tc_o(rx_tc)
  );

  assign bus.rx_data        = rx_data_q;
  assign bus.rx_valid       = rx_valid_q;
  assign bus.rx_parity_err  = rx_perr_q;
  assign bus.rx_framing_err = rx_ferr_q;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
    end else begin
      rx_meta_q  <= bus.rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:   if (!rx_sync_q) rx_state_d = RX_START;
      RX_START:  if (rx_tc) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tc && rx_cnt_q == LAST_DATA)
                   rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tc) rx_state_d = RX_STOP;
      RX_STOP:   if (rx_tc) rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (rx_sync_q) rx_state_d = RX_IDLE;
      default:   rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_load     = 1'b0;
    rx_load_val = BIT_LOAD;
    unique case (rx_state_q)
      RX_IDLE:                     begin rx_load = !rx_sync_q; rx_load_val = HALF_LOAD; end
      RX_START, RX_DATA, RX_PARITY: rx_load = rx_tc;
      default:                     ;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_cnt_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: rx_cnt_q <= '0;
        RX_DATA: if (rx_tc) begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
          rx_cnt_q   <= rx_cnt_q + 1'b1;
        end
        RX_PARITY: if (rx_tc) rx_par_q <= rx_sync_q;
        RX_STOP: if (rx_tc) begin
          rx_data_q  <= rx_shift_q;
          rx_perr_q  <= (PARITY_EN != 0) &&
                        (rx_par_q != parity_calc(MAX_DATA_WIDTH'(rx_shift_q), ODD_MODE));
          rx_ferr_q  <= !rx_sync_q;
          rx_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_serial_device.sv
// Directed bench: cross-connected default pair A/B plus an odd-parity endpoint P driven directly.
module tb_uart_serial_device;
  logic       pclk   = 1'b0;
  logic       areset = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] drv_data [3];
  logic [2:0] drv_valid;
  logic [2:0] rdy;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fails  = 0;

  logic [7:0] a_words[$], b_words[$], p_words[$];
  logic [1:0] a_errs[$],  b_errs[$],  p_errs[$];
  int         b_cycs[$];

  int    tx_offs [5] = '{8, 24, 56, 152, 168};
  logic  tx_exp  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  string tx_tags [5] = '{"p_tx_start", "p_tx_bit0", "p_tx_bit2", "p_tx_parity", "p_tx_stop"};

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  uart_serial_device_if #(.DATA_WIDTH(8)) ifa ();
  uart_serial_device_if #(.DATA_WIDTH(8)) ifb ();
  uart_serial_device_if #(.DATA_WIDTH(8)) ifp ();

  assign ifa.rx = ifb.tx;
  assign ifb.rx = ifa.tx;
  assign ifp.rx = rx_drv;
  assign ifa.tx_data  = drv_data[0];
  assign ifb.tx_data  = drv_data[1];
  assign ifp.tx_data  = drv_data[2];
  assign ifa.tx_valid = drv_valid[0];
  assign ifb.tx_valid = drv_valid[1];
  assign ifp.tx_valid = drv_valid[2];
  assign rdy = {ifp.tx_ready, ifb.tx_ready, ifa.tx_ready};

  uart_serial_device u_a (.pclk(pclk), .areset(areset), .bus(ifa));
  uart_serial_device u_b (.pclk(pclk), .areset(areset), .bus(ifb));
  uart_serial_device #(.PARITY_EN(1), .PARITY_ODD(1)) u_p (.pclk(pclk), .areset(areset), .bus(ifp));

  always @(negedge pclk) begin
    if (ifa.rx_valid) begin
      a_words.push_back(ifa.rx_data);
      a_errs.push_back({ifa.rx_parity_err, ifa.rx_framing_err});
    end
    if (ifb.rx_valid) begin
      b_words.push_back(ifb.rx_data);
      b_errs.push_back({ifb.rx_parity_err, ifb.rx_framing_err});
      b_cycs.push_back(cyc);
    end
    if (ifp.rx_valid) begin
      p_words.push_back(ifp.rx_data);
      p_errs.push_back({ifp.rx_parity_err, ifp.rx_framing_err});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    a_words.delete(); b_words.delete(); p_words.delete();
    a_errs.delete();  b_errs.delete();  p_errs.delete();
    b_cycs.delete();
  endtask

  // Returns the cycle count sampled at the negedge right after the accepting edge.
  task automatic send(input int idx, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge pclk);
    while (!rdy[idx] && n < 400) begin
      @(negedge pclk);
      n++;
    end
    check_eq("send_ready_seen", 32'(n < 400), 1);
    drv_data[idx]  = d;
    drv_valid[idx] = 1'b1;
    @(negedge pclk);
    acc            = cyc;
    drv_valid[idx] = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop, input logic after);
    @(negedge pclk);
    rx_drv = 1'b0;
    repeat (16) @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (16) @(negedge pclk);
    end
    rx_drv = par;
    repeat (16) @(negedge pclk);
    rx_drv = stop;
    repeat (16) @(negedge pclk);
    rx_drv = after;
  endtask

  initial begin
    int acc;
    int k;
    for (int i = 0; i < 3; i++) drv_data[i] = 8'h00;
    drv_valid = '0;

    repeat (3) @(negedge pclk);
    check_eq("rst_tx",       ifa.tx, 1);
    check_eq("rst_tx_ready", ifa.tx_ready, 0);
    check_eq("rst_rx_valid", ifb.rx_valid, 0);
    check_eq("rst_rx_data",  ifp.rx_data, 0);
    check_eq("rst_errs",     {ifp.rx_parity_err, ifp.rx_framing_err}, 0);
    areset = 1'b1;
    #1 check_eq("rel_ready_before_edge", ifa.tx_ready, 0);
    @(posedge pclk);
    #1 check_eq("rel_ready_first_edge", ifa.tx_ready, 1);

    clear_logs();
    send(0, 8'hA5, acc);
    repeat (200) @(negedge pclk);
    check_eq("lb_count",   b_words.size(), 1);
    check_eq("lb_data",    b_words[0], 8'hA5);
    check_eq("lb_errs",    b_errs[0], 2'b00);
    check_eq("lb_latency", 32'((b_cycs[0] - acc >= 152) && (b_cycs[0] - acc <= 158)), 1);
    check_eq("lb_a_quiet", a_words.size(), 0);

    clear_logs();
    @(negedge pclk);
    check_eq("fd_both_ready", rdy[1:0], 2'b11);
    drv_data[0] = 8'h00;
    drv_data[1] = 8'hFF;
    drv_valid   = 3'b011;
    @(negedge pclk);
    drv_valid   = '0;
    repeat (200) @(negedge pclk);
    check_eq("fd_b_count", b_words.size(), 1);
    check_eq("fd_b_data",  b_words[0], 8'h00);
    check_eq("fd_b_errs",  b_errs[0], 2'b00);
    check_eq("fd_a_count", a_words.size(), 1);
    check_eq("fd_a_data",  a_words[0], 8'hFF);
    check_eq("fd_a_errs",  a_errs[0], 2'b00);

    clear_logs();
    @(negedge pclk);
    drv_data[0]  = 8'h55;
    drv_valid[0] = 1'b1;
    @(negedge pclk);
    drv_data[0]  = 8'hAA;
    k = 0;
    while (!rdy[0] && k < 400) begin
      @(negedge pclk);
      k++;
    end
    @(negedge pclk);
    drv_valid[0] = 1'b0;
    repeat (200) @(negedge pclk);
    check_eq("b2b_count", b_words.size(), 2);
    check_eq("b2b_first", b_words[0], 8'h55);
    check_eq("b2b_second", b_words[1], 8'hAA);
    check_eq("b2b_gap", b_cycs[1] - b_cycs[0], 161);

    clear_logs();
    send(2, 8'h03, acc);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      while (k < tx_offs[i]) begin
        @(negedge pclk);
        k++;
      end
      check_eq(tx_tags[i], ifp.tx, tx_exp[i]);
    end
    while (k < 175) begin
      @(negedge pclk);
      k++;
    end
    check_eq("p_ready_last_stop", ifp.tx_ready, 0);
    @(negedge pclk);
    check_eq("p_ready_frame_end", ifp.tx_ready, 1);

    clear_logs();
    @(negedge pclk);
    rx_drv = 1'b0;
    repeat (4) @(negedge pclk);
    rx_drv = 1'b1;
    repeat (250) @(negedge pclk);
    check_eq("glitch_no_valid", p_words.size(), 0);

    drive_frame(8'h03, 1'b0, 1'b1, 1'b1);
    repeat (40) @(negedge pclk);
    check_eq("perr_count", p_words.size(), 1);
    check_eq("perr_data",  p_words[0], 8'h03);
    check_eq("perr_flags", p_errs[0], 2'b10);

    clear_logs();
    drive_frame(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge pclk);
    check_eq("ferr_count", p_words.size(), 1);
    check_eq("ferr_data",  p_words[0], 8'h81);
    check_eq("ferr_flags", p_errs[0], 2'b01);
    repeat (300) @(negedge pclk);
    check_eq("break_no_rearm", p_words.size(), 1);
    rx_drv = 1'b1;
    repeat (20) @(negedge pclk);
    drive_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge pclk);
    check_eq("recover_count", p_words.size(), 2);
    check_eq("recover_data",  p_words[1], 8'h5A);
    check_eq("recover_flags", p_errs[1], 2'b00);

    clear_logs();
    send(0, 8'hA5, acc);
    repeat (70) @(negedge pclk);
    check_eq("mid_tx_bit3_low", ifa.tx, 0);
    areset = 1'b0;
    #1;
    check_eq("mid_tx_high", ifa.tx, 1);
    check_eq("mid_ready_low", ifa.tx_ready, 0);
    repeat (3) @(negedge pclk);
    areset = 1'b1;
    repeat (5) @(negedge pclk);
    send(0, 8'h3C, acc);
    repeat (200) @(negedge pclk);
    check_eq("post_rst_count", b_words.size(), 1);
    check_eq("post_rst_data",  b_words[0], 8'h3C);
    check_eq("post_rst_errs",  b_errs[0], 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
